flash_sdram_loader: RTL and testbench

- Boot-time controller that copies a block of words from SPI flash into SDRAM, then hands the SDRAM port to the chipset.
- Sequences the flash word-read engine (cs/busy/dout) and the SDRAM single-port controller (addr/cs/we/ds/din/refresh).
- Arbitrates SDRAM ownership: the loader owns it while copying, and the chipset (gstmcu) owns it once done.
- Generates the debounced chipset reset, which stays asserted until the copy completes.

---
 rtl/loader_pkg.sv | 22 ++
 rtl/reset_debounce.sv | 25 ++
 rtl/flash_sdram_loader.sv | 149 ++++++++++++++
 tb/tb_flash_sdram_loader.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and default constants for the flash-to-SDRAM boot loader.
package loader_pkg;

    typedef logic [21:0] word_addr_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam word_addr_t DEF_FLASH_BASE    = 22'h100000;
    localparam word_addr_t DEF_RAM_BASE      = 22'h0fc000;
    localparam word_addr_t DEF_WORD_COUNT    = 22'd16000;
    localparam logic [5:0] DEF_ACCESS_CYCLES = 6'd30;
    localparam logic [2:0] DEF_WRITE_CYCLES  = 3'd6;
    localparam int         DEF_DEBOUNCE_BITS = 5;

endpackage

// File: rtl/reset_debounce.sv
// Holds the chipset in reset until the loader has been done for 2^BITS-1 clocks.
module reset_debounce #(
    parameter int BITS = 5
) (
    input  logic clk,
    input  logic resb,
    input  logic done,
    output logic chip_reset_n
);

    logic [BITS-1:0] count;

    // NOTE: reset is synchronous (sampled on the clock edge) and all state uses
    // non-blocking assignments so every flop updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (!resb || !done) begin
            count <= '0;
        end else if (!(&count)) begin
            count <= count + 1'b1;
        end
    end

    assign chip_reset_n = &count;

endmodule

// File: rtl/flash_sdram_loader.sv
// Boot loader: copies WORD_COUNT words from SPI flash to SDRAM, then hands the
// SDRAM port to the chipset. Define LOADER_BUSY_HANDSHAKE_EN to end each flash
// read on the falling edge of flash_busy, with the access counter as a timeout.
module flash_sdram_loader
    import loader_pkg::*;
#(
    parameter word_addr_t FLASH_BASE    = DEF_FLASH_BASE,
    parameter word_addr_t RAM_BASE      = DEF_RAM_BASE,
    parameter word_addr_t WORD_COUNT    = DEF_WORD_COUNT,
    parameter logic [5:0] ACCESS_CYCLES = DEF_ACCESS_CYCLES,
    parameter logic [2:0] WRITE_CYCLES  = DEF_WRITE_CYCLES,
    parameter int         DEBOUNCE_BITS = DEF_DEBOUNCE_BITS
) (
    input  logic        clk32,
    input  logic        resb,
    input  logic        flash_ready,
    input  logic        sdram_ready,
    output logic        flash_cs,
    output logic [21:0] flash_addr,
    input  logic        flash_busy,
    input  logic [15:0] flash_dout,
    input  logic [21:0] cpu_addr,
    input  logic        cpu_cs,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_ds,
    input  logic [15:0] cpu_din,
    input  logic        cpu_refresh,
    output logic [21:0] sd_addr,
    output logic        sd_cs,
    output logic        sd_we,
    output logic [1:0]  sd_ds,
    output logic [15:0] sd_din,
    output logic        sd_refresh,
    output logic        done,
    output logic        chip_reset_n
);

    state_t      state;
    word_addr_t  ram_addr;
    word_addr_t  remaining;
    logic [15:0] data_latch;
    logic [5:0]  acc_cnt;
    logic [2:0]  wr_cnt;
    logic        ready;
    logic        read_done;

    assign ready = flash_ready && sdram_ready;
    assign done  = (state == ST_DONE);

`ifdef LOADER_BUSY_HANDSHAKE_EN
    logic busy_q;

    always_ff @(posedge clk32) begin
        if (!resb) busy_q <= 1'b0;
        else       busy_q <= flash_busy;
    end

    assign read_done = (acc_cnt == 6'd1) || (busy_q && !flash_busy);
`else
    assign read_done = (acc_cnt == 6'd1);
`endif

    always_ff @(posedge clk32) begin
        if (!resb) begin
            state      <= ST_IDLE;
            flash_cs   <= 1'b0;
            flash_addr <= FLASH_BASE;
            ram_addr   <= RAM_BASE;
            remaining  <= WORD_COUNT;
            data_latch <= '0;
            acc_cnt    <= '0;
            wr_cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ready) state <= (remaining == '0) ? ST_DONE : ST_REQ;
                end
                ST_REQ: begin
                    if (ready) begin
                        flash_cs <= 1'b1;
                        acc_cnt  <= ACCESS_CYCLES;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // cs only needs to be held until the engine acknowledges with busy
                    if (flash_busy) flash_cs <= 1'b0;
                    if (ready) begin
                        acc_cnt <= acc_cnt - 6'd1;
                        if (read_done) begin
                            data_latch <= flash_dout;
                            flash_cs   <= 1'b0;
                            wr_cnt     <= WRITE_CYCLES;
                            state      <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    // a write in flight always runs to completion, ready or not
                    if (wr_cnt == 3'd1) state <= ST_NEXT;
                    else                wr_cnt <= wr_cnt - 3'd1;
                end
                ST_NEXT: begin
                    if (ready) begin
                        flash_addr <= flash_addr + 22'd1;
                        ram_addr   <= ram_addr + 22'd1;
                        remaining  <= remaining - 22'd1;
                        state      <= (remaining == 22'd1) ? ST_DONE : ST_REQ;
                    end
                end
                ST_DONE: ;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default at the top of always_comb so no path
    // leaves one unassigned and a latch cannot be inferred.
    always_comb begin
        sd_addr    = ram_addr;
        sd_din     = data_latch;
        sd_cs      = 1'b0;
        sd_we      = 1'b0;
        sd_ds      = 2'b00;
        sd_refresh = 1'b0;
        if (done) begin
            sd_addr    = cpu_addr;
            sd_din     = cpu_din;
            sd_cs      = cpu_cs;
            sd_we      = cpu_we;
            sd_ds      = cpu_ds;
            sd_refresh = cpu_refresh;
        end else if (state == ST_WRITE) begin
            sd_cs = 1'b1;
            sd_we = 1'b1;
            sd_ds = 2'b11;
        end
    end

    reset_debounce #(
        .BITS(DEBOUNCE_BITS)
    ) u_debounce (
        .clk         (clk32),
        .resb        (resb),
        .done        (done),
        .chip_reset_n(chip_reset_n)
    );

endmodule

// File: tb/tb_flash_sdram_loader.sv
// Self-checking bench for flash_sdram_loader: flash/SDRAM behavioural models,
// per-cycle compare process, and literal pins for the documented scenarios.
module tb_flash_sdram_loader;

    localparam logic [21:0] FB  = 22'h100000;
    localparam logic [21:0] RB  = 22'h0fc000;
    localparam int          N   = 3;
    localparam int          ACC = 30;
    localparam int          WR  = 6;
    localparam int          DB  = 5;

    logic clk32 = 1'b0;
    always #5 clk32 = ~clk32;

    logic        resb, flash_ready, sdram_ready;
    logic        flash_busy;
    logic [15:0] flash_dout;
    logic [21:0] cpu_addr;
    logic        cpu_cs, cpu_we, cpu_refresh;
    logic [1:0]  cpu_ds;
    logic [15:0] cpu_din;

    logic        flash_cs, sd_cs, sd_we, sd_refresh, done, chip_reset_n;
    logic [21:0] flash_addr, sd_addr;
    logic [1:0]  sd_ds;
    logic [15:0] sd_din;

    logic        z_flash_cs, z_sd_cs, z_sd_we, z_sd_refresh, z_done, z_crn;
    logic [21:0] z_flash_addr, z_sd_addr;
    logic [1:0]  z_sd_ds;
    logic [15:0] z_sd_din;

    logic        w_flash_cs, w_sd_cs, w_sd_we, w_sd_refresh, w_done, w_crn;
    logic [21:0] w_flash_addr, w_sd_addr;
    logic [1:0]  w_sd_ds;
    logic [15:0] w_sd_din;

    flash_sdram_loader #(
        .WORD_COUNT(22'd3)
    ) u_dut (
        .clk32(clk32), .resb(resb), .flash_ready(flash_ready), .sdram_ready(sdram_ready),
        .flash_cs(flash_cs), .flash_addr(flash_addr), .flash_busy(flash_busy), .flash_dout(flash_dout),
        .cpu_addr(cpu_addr), .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_ds(cpu_ds), .cpu_din(cpu_din),
        .cpu_refresh(cpu_refresh), .sd_addr(sd_addr), .sd_cs(sd_cs), .sd_we(sd_we), .sd_ds(sd_ds),
        .sd_din(sd_din), .sd_refresh(sd_refresh), .done(done), .chip_reset_n(chip_reset_n)
    );

    flash_sdram_loader #(
        .WORD_COUNT(22'd0)
    ) u_zero (
        .clk32(clk32), .resb(resb), .flash_ready(flash_ready), .sdram_ready(sdram_ready),
        .flash_cs(z_flash_cs), .flash_addr(z_flash_addr), .flash_busy(1'b0), .flash_dout(16'h0000),
        .cpu_addr(cpu_addr), .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_ds(cpu_ds), .cpu_din(cpu_din),
        .cpu_refresh(cpu_refresh), .sd_addr(z_sd_addr), .sd_cs(z_sd_cs), .sd_we(z_sd_we), .sd_ds(z_sd_ds),
        .sd_din(z_sd_din), .sd_refresh(z_sd_refresh), .done(z_done), .chip_reset_n(z_crn)
    );

    // Address wrap at the top of the 22-bit space, with minimum access/write timing.
    flash_sdram_loader #(
        .FLASH_BASE(22'h3ffffe), .RAM_BASE(22'h3fffff), .WORD_COUNT(22'd3),
        .ACCESS_CYCLES(6'd2), .WRITE_CYCLES(3'd1)
    ) u_wrap (
        .clk32(clk32), .resb(resb), .flash_ready(flash_ready), .sdram_ready(sdram_ready),
        .flash_cs(w_flash_cs), .flash_addr(w_flash_addr), .flash_busy(1'b0), .flash_dout(w_flash_addr[15:0]),
        .cpu_addr(cpu_addr), .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_ds(cpu_ds), .cpu_din(cpu_din),
        .cpu_refresh(cpu_refresh), .sd_addr(w_sd_addr), .sd_cs(w_sd_cs), .sd_we(w_sd_we), .sd_ds(w_sd_ds),
        .sd_din(w_sd_din), .sd_refresh(w_sd_refresh), .done(w_done), .chip_reset_n(w_crn)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Flash read completes at this many clocks after cs rises, given the busy pattern.
    function automatic int valid_time(input int mode);
`ifdef LOADER_BUSY_HANDSHAKE_EN
        return (mode == 0) ? 5 : ACC;
`else
        return ACC;
`endif
    endfunction

    // Chipset stimulus: random every cycle, changed away from the sampling edge.
    bit cpu_hold = 1'b0;
    initial begin
        cpu_addr = '0; cpu_cs = 0; cpu_we = 0; cpu_ds = '0; cpu_din = '0; cpu_refresh = 0;
        forever begin
            @(posedge clk32);
            #2;
            if (!cpu_hold) begin
                cpu_addr    = 22'($urandom);
                cpu_cs      = 1'($urandom);
                cpu_we      = 1'($urandom);
                cpu_ds      = 2'($urandom);
                cpu_din     = 16'($urandom);
                cpu_refresh = 1'($urandom);
            end
        end
    end

    // Flash engine model. busy_mode 0: busy high on clocks 2..4 of a read,
    // 1: busy never rises, 2: busy stuck high from clock 2.
    int          busy_mode = 0;
    int          t_valid   = ACC;
    bit          addr_data = 1'b1;
    int          t, rd_idx;
    bit          reading, prev_cs;
    logic [15:0] cur_data;
    logic [15:0] exp_data [N];

    initial begin
        flash_busy = 1'b0;
        flash_dout = '0;
    end

    always @(negedge clk32) begin
        if (!resb) begin
            reading = 0; t = 0; rd_idx = 0; prev_cs = 0;
            flash_busy = 1'b0;
            flash_dout = 16'($urandom);
        end else begin
            if (flash_cs && !prev_cs) begin
                check("flash_addr_at_cs", flash_addr, FB + 22'(rd_idx));
                cur_data = addr_data ? 16'(FB + 22'(rd_idx)) : 16'($urandom);
                if (rd_idx < N) exp_data[rd_idx] = cur_data;
                rd_idx++;
                reading = 1;
                t = 1;
            end else if (reading) begin
                t++;
                if (t > t_valid) reading = 0;
            end
            prev_cs = flash_cs;
            if (reading) check("flash_cs_hold", flash_cs, (busy_mode == 1) ? 1 : ((t <= 2) ? 1 : 0));
            flash_busy = reading && ((busy_mode == 0 && t >= 2 && t <= 4) || (busy_mode == 2 && t >= 2));
            flash_dout = !reading ? 16'($urandom) : (t == t_valid) ? cur_data : ~cur_data;
        end
    end

    // SDRAM scoreboard, mux and chipset-reset checks on every cycle.
    int          wr_idx, pulse, dcnt;
    logic [21:0] wl_addr[$];
    logic [15:0] wl_data[$];

    always @(negedge clk32) begin
        if (!resb) begin
            wr_idx = 0; pulse = 0; dcnt = 0;
            wl_addr.delete(); wl_data.delete();
        end else begin
            if (!done) begin
                check("loader_refresh", sd_refresh, 0);
                if (sd_cs) begin
                    check("wr_we", sd_we, 1);
                    check("wr_ds", sd_ds, 2'b11);
                    check("wr_addr", sd_addr, RB + 22'(wr_idx));
                    check("wr_din", sd_din, (wr_idx < N) ? exp_data[wr_idx] : 16'hxxxx);
                    if (pulse == 0) begin
                        wl_addr.push_back(sd_addr);
                        wl_data.push_back(sd_din);
                    end
                    pulse++;
                end else begin
                    check("idle_we", sd_we, 0);
                    if (pulse != 0) begin
                        check("wr_pulse_len", pulse, WR);
                        wr_idx++;
                        pulse = 0;
                    end
                end
            end else begin
                check("pt_addr", sd_addr, cpu_addr);
                check("pt_cs", sd_cs, cpu_cs);
                check("pt_we", sd_we, cpu_we);
                check("pt_ds", sd_ds, cpu_ds);
                check("pt_din", sd_din, cpu_din);
                check("pt_refresh", sd_refresh, cpu_refresh);
            end
            dcnt = done ? dcnt + 1 : 0;
            check("chip_reset_n", chip_reset_n, (dcnt >= (1 << DB)) ? 1 : 0);
        end
    end

    // Side instances: zero-count never writes; wrap instance logs its addresses.
    logic [21:0] w_fa_q[$], w_sa_q[$];
    logic [15:0] w_d_q[$];
    bit          w_prev_cs, w_prev_sd;

    always @(negedge clk32) begin
        if (!z_done) check("zero_no_sd_cs", z_sd_cs, 0);
        if (!resb) begin
            w_fa_q.delete(); w_sa_q.delete(); w_d_q.delete();
            w_prev_cs = 0; w_prev_sd = 0;
        end else begin
            if (w_flash_cs && !w_prev_cs) w_fa_q.push_back(w_flash_addr);
            if (!w_done && w_sd_cs && !w_prev_sd) begin
                w_sa_q.push_back(w_sd_addr);
                w_d_q.push_back(w_sd_din);
            end
            w_prev_cs = w_flash_cs;
            w_prev_sd = w_sd_cs && !w_done;
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_flash_cs"}, flash_cs, 0);
        check({tag, "_flash_addr"}, flash_addr, FB);
        check({tag, "_done"}, done, 0);
        check({tag, "_chip_reset_n"}, chip_reset_n, 0);
        check({tag, "_sd_cs"}, sd_cs, 0);
        check({tag, "_sd_refresh"}, sd_refresh, 0);
    endtask

    // Full copy from reset; optionally aborts with a reset during write abort_word.
    task automatic do_copy(input int mode, input bit use_addr, input int abort_word);
        int  n;
        int  abort_at;
        bit  aborted;
        abort_at = abort_word;
        aborted  = 0;
        @(negedge clk32); #2 resb = 1'b0;
        @(negedge clk32);
        check_reset_values("rst");
        #2;
        busy_mode = mode;
        addr_data = use_addr;
        t_valid   = valid_time(mode);
        resb      = 1'b1;
        n = 0;
        while (!done && n < 5000) begin
            @(posedge clk32); n++;
            @(negedge clk32);
            if (abort_at >= 0 && wr_idx == abort_at && sd_cs) begin
                #2 resb = 1'b0;
                @(negedge clk32);
                check_reset_values("abort");
                #2 resb = 1'b1;
                n = 0;
                abort_at = -1;
                aborted = 1;
            end
        end
        if (abort_word >= 0) check("abort_reached", aborted, 1);
        check("done_latency", n, N * (t_valid + WR + 2) + 1);
        check("words_written", wr_idx, N);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        resb = 1'b0; flash_ready = 1'b0; sdram_ready = 1'b0;
        t_valid = valid_time(0);
        repeat (3) @(negedge clk32);
        check_reset_values("init");

        // Flash ready, SDRAM not: nothing may start.
        #2 resb = 1'b1; flash_ready = 1'b1;
        repeat (100) begin
            @(negedge clk32);
            check("stall_no_cs", flash_cs, 0);
        end
        #2 sdram_ready = 1'b1;
        @(posedge clk32);
        @(negedge clk32);
        check("zero_done_1clk", z_done, 1);
        check("main_not_done_1clk", done, 0);
        n = 1;
        while (!flash_cs && n < 10) begin
            @(posedge clk32); n++;
            @(negedge clk32);
        end
        check("start_latency", n, 2);
        while (!done && n < 5000) begin
            @(posedge clk32); n++;
            @(negedge clk32);
        end
        check("done_latency", n, N * (t_valid + WR + 2) + 1);
`ifndef LOADER_BUSY_HANDSHAKE_EN
        check("done_latency_literal", n, 115);
`endif

        // Literal pins for the first copy.
        check("log_size", wl_addr.size(), 3);
        if (wl_addr.size() == 3) begin
            check("log0_addr", wl_addr[0], 22'h0fc000); check("log0_data", wl_data[0], 16'h0000);
            check("log1_addr", wl_addr[1], 22'h0fc001); check("log1_data", wl_data[1], 16'h0001);
            check("log2_addr", wl_addr[2], 22'h0fc002); check("log2_data", wl_data[2], 16'h0002);
        end

        n = 0;
        while (!chip_reset_n && n < 100) begin
            @(posedge clk32); n++;
            @(negedge clk32);
        end
        check("chip_reset_delay", n, 31);

        check("wrap_done", w_done, 1);
        check("wrap_reads", w_fa_q.size(), 3);
        check("wrap_writes", w_sa_q.size(), 3);
        if (w_fa_q.size() == 3 && w_sa_q.size() == 3) begin
            check("wrap_fa0", w_fa_q[0], 22'h3ffffe); check("wrap_fa1", w_fa_q[1], 22'h3fffff);
            check("wrap_fa2", w_fa_q[2], 22'h000000);
            check("wrap_sa0", w_sa_q[0], 22'h3fffff); check("wrap_sa1", w_sa_q[1], 22'h000000);
            check("wrap_sa2", w_sa_q[2], 22'h000001);
            check("wrap_d0", w_d_q[0], 16'hfffe); check("wrap_d1", w_d_q[1], 16'hffff);
            check("wrap_d2", w_d_q[2], 16'h0000);
        end

        // Same-cycle pass-through of a fixed chipset request.
        @(negedge clk32);
        #2;
        cpu_hold = 1'b1;
        cpu_addr = 22'h123456; cpu_cs = 1'b1; cpu_we = 1'b0;
        cpu_ds = 2'b01; cpu_din = 16'hbeef; cpu_refresh = 1'b1;
        #1;
        check("mux_addr", sd_addr, 22'h123456);
        check("mux_cs", sd_cs, 1);
        check("mux_ds", sd_ds, 2'b01);
        check("mux_refresh", sd_refresh, 1);
        check("mux_din", sd_din, 16'hbeef);
        @(negedge clk32);
        #2 cpu_hold = 1'b0;

        do_copy($urandom_range(0, 2), 1'b0, 1);
        do_copy(1, 1'b0, -1);
        do_copy(2, 1'b0, -1);
        do_copy(0, 1'b0, -1);
        repeat (40) @(negedge clk32);
        check("final_chip_reset_n", chip_reset_n, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
